i2s_frame_scheduler: RTL and testbench
======================================

# i2s_frame_scheduler

Frame-level sequencer for the monochrome I2S video serializer toward the ESP. It watches camera `v_sync` and the ESP's `cts` (clear-to-send) flow control, decides frame by frame whether to transmit, and drives the serializer's `send_frame` gate. It applies frame decimation, counts accepted pixels so each transmitted frame is exactly complete, and aborts a short frame cleanly. It runs in the `mclk` domain between the camera timing logic and the serializer, and replaces ad-hoc `v_sync`-edge gating.

## Interface
Parameters:
- `FRAME_PIXELS`, 307200: pixels per transmitted frame (640x480).
- `PIX_CNT_W`, 19: width of the pixel counter; must satisfy 2^PIX_CNT_W > FRAME_PIXELS.
- `DECIM_W`, 4: width of the decimation setting.

Ports:
- `mclk` in 1: the only clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: scheduler run enable, synchronous to `mclk`.
- `v_sync` in 1: camera vertical sync, asynchronous; a falling edge marks the frame boundary.
- `cts` in 1: ESP clear-to-send, asynchronous level.
- `datavalid` in 1: camera pixel-valid qualifier, synchronous to `mclk`.
- `pix_strobe` in 1: one-cycle pulse from the serializer per pixel slot, synchronous.
- `decim` in DECIM_W: send 1 of every `decim+1` eligible frames; sampled at each frame boundary.
- `send_frame` out 1: gate to the serializer.
- `frame_start` out 1: one-cycle pulse when transmission begins.
- `frame_done` out 1: one-cycle pulse when FRAME_PIXELS pixels have been sent.
- `frame_abort` out 1: one-cycle pulse when a frame is cut short by `v_sync`.
- `busy` out 1: high while in SEND.
- `sent_count` out 16: completed frames; saturates at 0xFFFF.
- `dropped_count` out 16: frame boundaries lost to `cts` low or to an abort; saturates at 0xFFFF.

## Operation
Input conditioning:
- `v_sync` and `cts` each pass through a 2-flop synchronizer.
- `vs_fall` = previous synchronized `v_sync` AND NOT current synchronized `v_sync`.
- `vs_fall` is a one-cycle pulse.

State machine (IDLE / WAIT_VS / SEND):
- **IDLE**: `send_frame` = 0.
  - `enable` = 1 moves to WAIT_VS on the next cycle.
  - `vs_fall` is ignored and not counted.
- **WAIT_VS**: `enable` = 0 returns to IDLE.
  - On `vs_fall` with synchronized `cts` = 0: increment `dropped_count`, stay in WAIT_VS. `decim_cnt` is unchanged.
  - On `vs_fall` with `cts` = 1 and `decim_cnt` != 0: decrement `decim_cnt`, stay in WAIT_VS. This is a skip, not a drop.
  - On `vs_fall` with `cts` = 1 and `decim_cnt` = 0: load `decim_cnt` with `decim`, clear `pix_cnt`, pulse `frame_start`, go to SEND.
- **SEND**: `send_frame` = 1, `busy` = 1.
  - Each cycle with `pix_strobe` AND `datavalid` increments `pix_cnt`.
  - When the increment takes `pix_cnt` to FRAME_PIXELS: pulse `frame_done`, increment `sent_count`.
    - Go to WAIT_VS if `enable` = 1, otherwise IDLE.
  - `vs_fall` before completion: pulse `frame_abort`, increment `dropped_count`, go to WAIT_VS.
    - The aborting edge is consumed; it does not start a new frame.
  - A completing strobe in the same cycle as `vs_fall`: completion wins.
    - `frame_done` fires, no abort.
    - The edge is consumed without incrementing `dropped_count`.
  - `cts` falling mid-frame has no effect; `cts` is sampled only at frame boundaries.
  - `enable` falling mid-frame: the frame finishes, then the block goes to IDLE.

Arithmetic:
- `decim` = 0 sends every eligible frame.
- `decim` changes take effect only at the next reload.

## Timing
- Reset values:
  - state = IDLE.
  - `send_frame`, `busy`, `frame_start`, `frame_done`, `frame_abort` = 0.
  - `sent_count`, `dropped_count`, `pix_cnt`, `decim_cnt` = 0.
  - Synchronizer flops reset to `v_sync` = 1 and `cts` = 0, so no false edge occurs after reset.
- `v_sync` falling at the input: `vs_fall` is seen on rising edge 3, and `send_frame` and `frame_start` are high after edge 3.
- `send_frame` drops on the edge that registers the last counted pixel. `frame_done` is high for the cycle that follows.
- All status outputs are registered; there is no combinational path from input to output.
- Asserting `reset` during SEND immediately forces `send_frame` = 0. The frame is not counted as done or dropped.

## Test plan
Benches use FRAME_PIXELS = 16.
- **Basic frame**: `enable` = 1, `cts` = 1, `decim` = 0, one `v_sync` fall, 16 qualified strobes -> `frame_start` ×1, `send_frame` high for 16 strobes, `frame_done` ×1, `sent_count` = 1, `dropped_count` = 0.
- **No clear-to-send**: `cts` = 0 over 3 `v_sync` falls -> `send_frame` never high, `dropped_count` = 3, `sent_count` = 0.
- **Decimation**: `decim` = 2, 9 `v_sync` falls with full frames between them -> frames sent on falls 1, 4, 7, `sent_count` = 3, `dropped_count` = 0.
- **Abort**: `v_sync` falls after 10 strobes -> `frame_abort` ×1, `dropped_count` = 1, state WAIT_VS. The next fall starts a fresh frame with `pix_cnt` = 0.
- **Simultaneous events**: 16th strobe coincides with `vs_fall` -> `frame_done` ×1, no `frame_abort`, counters = (1, 0). Separately, `datavalid` = 0 on 4 strobes -> 20 strobes needed to complete.
- **Reset and enable**: `reset` pulsed mid-SEND -> every output returns to 0 asynchronously. `enable` dropped mid-frame -> the frame completes, then IDLE, and later `v_sync` falls are ignored.

Source files
------------

// File: rtl/i2s_frame_scheduler.sv
// Frame-level gate for the I2S pixel serializer: picks which camera frames go out,
// counts accepted pixels to close each frame, and aborts frames cut short by v_sync.
module i2s_frame_scheduler #(
  parameter int FRAME_PIXELS = 307200,
  parameter int PIX_CNT_W    = 19,
  parameter int DECIM_W      = 4
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic               enable,
  input  logic               v_sync,
  input  logic               cts,
  input  logic               datavalid,
  input  logic               pix_strobe,
  input  logic [DECIM_W-1:0] decim,
  output logic               send_frame,
  output logic               frame_start,
  output logic               frame_done,
  output logic               frame_abort,
  output logic               busy,
  output logic [15:0]        sent_count,
  output logic [15:0]        dropped_count
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, SEND} state_t;

  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(FRAME_PIXELS - 1);

  state_t               state;
  logic                 vs_s1, vs_s2, vs_prev;
  logic                 cts_s1, cts_s2;
  logic [PIX_CNT_W-1:0] pix_cnt;
  logic [DECIM_W-1:0]   decim_cnt;
  logic                 vs_fall, pix_hit, last_hit;

  // v_sync side resets high so the release of reset never looks like a frame edge
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      vs_s1   <= 1'b1;
      vs_s2   <= 1'b1;
      vs_prev <= 1'b1;
      cts_s1  <= 1'b0;
      cts_s2  <= 1'b0;
    end else begin
      vs_s1   <= v_sync;
      vs_s2   <= vs_s1;
      vs_prev <= vs_s2;
      cts_s1  <= cts;
      cts_s2  <= cts_s1;
    end
  end

  assign vs_fall  = vs_prev & ~vs_s2;
  assign pix_hit  = pix_strobe & datavalid;
  assign last_hit = pix_hit && (pix_cnt == LAST_PIX);

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      send_frame    <= 1'b0;
      busy          <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      frame_abort   <= 1'b0;
      sent_count    <= '0;
      dropped_count <= '0;
      pix_cnt       <= '0;
      decim_cnt     <= '0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          send_frame <= 1'b0;
          busy       <= 1'b0;
          if (enable) state <= WAIT_VS;
        end
        WAIT_VS: begin
          if (!enable) begin
            state <= IDLE;
          end else if (vs_fall) begin
            if (!cts_s2) begin
              if (dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
            end else if (decim_cnt != '0) begin
              decim_cnt <= decim_cnt - 1'b1;
            end else begin
              decim_cnt   <= decim;
              pix_cnt     <= '0;
              frame_start <= 1'b1;
              send_frame  <= 1'b1;
              busy        <= 1'b1;
              state       <= SEND;
            end
          end
        end
        SEND: begin
          // completion beats a coincident v_sync edge; that edge is simply consumed
          if (last_hit) begin
            pix_cnt    <= pix_cnt + 1'b1;
            frame_done <= 1'b1;
            send_frame <= 1'b0;
            busy       <= 1'b0;
            if (sent_count != 16'hFFFF) sent_count <= sent_count + 16'd1;
            state      <= enable ? WAIT_VS : IDLE;
          end else begin
            if (pix_hit) pix_cnt <= pix_cnt + 1'b1;
            if (vs_fall) begin
              frame_abort <= 1'b1;
              send_frame  <= 1'b0;
              busy        <= 1'b0;
              if (dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
              state       <= WAIT_VS;
            end
          end
        end
        default: begin
          send_frame <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Directed bench for i2s_frame_scheduler with a 16-pixel frame: scenario table
// plus hand sequences for edge timing, coincident events, reset and enable.
module tb_i2s_frame_scheduler;

  logic       mclk = 1'b0;
  logic       reset, enable, v_sync, cts, datavalid, pix_strobe;
  logic [3:0] decim;
  logic       send_frame, frame_start, frame_done, frame_abort, busy;
  logic [15:0] sent_count, dropped_count;

  i2s_frame_scheduler #(.FRAME_PIXELS(16), .PIX_CNT_W(5), .DECIM_W(4)) dut (
    .mclk(mclk), .reset(reset), .enable(enable), .v_sync(v_sync), .cts(cts),
    .datavalid(datavalid), .pix_strobe(pix_strobe), .decim(decim),
    .send_frame(send_frame), .frame_start(frame_start), .frame_done(frame_done),
    .frame_abort(frame_abort), .busy(busy), .sent_count(sent_count),
    .dropped_count(dropped_count)
  );

  always #5 mclk = ~mclk;

  int n_start = 0, n_done = 0, n_abort = 0, n_hi = 0;
  always @(posedge mclk) begin
    #1;
    if (frame_start) n_start++;
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
    if (send_frame)  n_hi++;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; pix_strobe = 1'b0; datavalid = 1'b0; v_sync = 1'b1;
    repeat (3) @(negedge mclk);
    reset = 1'b0;
    @(negedge mclk);
  endtask

  task automatic setup(input logic c, input logic [3:0] d);
    cts = c; decim = d; enable = 1'b1;
    repeat (5) @(negedge mclk);
  endtask

  task automatic vs_pulse();
    @(negedge mclk) v_sync = 1'b0;
    repeat (4) @(negedge mclk);
    v_sync = 1'b1;
    repeat (4) @(negedge mclk);
  endtask

  task automatic strobes(input int n, input int inv);
    for (int i = 0; i < n; i++) begin
      @(negedge mclk);
      pix_strobe = 1'b1; datavalid = (i >= inv);
      @(negedge mclk);
      pix_strobe = 1'b0; datavalid = 1'b0;
    end
  endtask

  typedef struct {
    logic       c;
    logic [3:0] d;
    int falls, nstb, inv;
    int e_sent, e_drop, e_start, e_done, e_abort, e_hi;
  } vec_t;
  vec_t tbl[6];

  int bs, bd, ba, bh;

  initial begin
    tbl[0] = '{1'b1, 4'd0, 1, 16, 0, 1, 0, 1, 1, 0, 1}; // basic frame
    tbl[1] = '{1'b0, 4'd0, 3, 16, 0, 0, 3, 0, 0, 0, 0}; // no clear-to-send
    tbl[2] = '{1'b1, 4'd2, 9, 16, 0, 3, 0, 3, 3, 0, 1}; // decimation 1 of 3
    tbl[3] = '{1'b1, 4'd1, 4, 16, 0, 2, 0, 2, 2, 0, 1}; // decimation 1 of 2
    tbl[4] = '{1'b1, 4'd0, 1, 20, 4, 1, 0, 1, 1, 0, 1}; // 4 unqualified strobes
    tbl[5] = '{1'b1, 4'd0, 3, 10, 0, 0, 1, 2, 0, 1, 1}; // short frames: abort, restart

    cts = 1'b0; decim = 4'd0; reset = 1'b1; enable = 1'b0;
    v_sync = 1'b1; pix_strobe = 1'b0; datavalid = 1'b0;
    repeat (2) @(negedge mclk);
    chk("rst_flags", {send_frame, busy, frame_start, frame_done, frame_abort}, 0);
    chk("rst_sent", sent_count, 0);
    chk("rst_drop", dropped_count, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      setup(tbl[i].c, tbl[i].d);
      bs = n_start; bd = n_done; ba = n_abort; bh = n_hi;
      for (int f = 0; f < tbl[i].falls; f++) begin
        vs_pulse();
        strobes(tbl[i].nstb, tbl[i].inv);
      end
      repeat (3) @(negedge mclk);
      chk($sformatf("v%0d_sent", i), sent_count, tbl[i].e_sent);
      chk($sformatf("v%0d_drop", i), dropped_count, tbl[i].e_drop);
      chk($sformatf("v%0d_starts", i), n_start - bs, tbl[i].e_start);
      chk($sformatf("v%0d_dones", i), n_done - bd, tbl[i].e_done);
      chk($sformatf("v%0d_aborts", i), n_abort - ba, tbl[i].e_abort);
      chk($sformatf("v%0d_send_seen", i), (n_hi - bh) > 0, tbl[i].e_hi);
    end

    // edge-3 latency, abort, then a fresh frame that must need all 16 pixels
    do_reset();
    setup(1'b1, 4'd0);
    ba = n_abort; bd = n_done;
    @(negedge mclk) v_sync = 1'b0;
    @(posedge mclk); @(posedge mclk); #1;
    chk("lat_edge2_send", send_frame, 0);
    @(posedge mclk); #1;
    chk("lat_edge3_send", send_frame, 1);
    chk("lat_edge3_start", frame_start, 1);
    @(negedge mclk) v_sync = 1'b1;
    repeat (3) @(negedge mclk);
    strobes(10, 0);
    vs_pulse();
    chk("abort_pulses", n_abort - ba, 1);
    chk("abort_drop", dropped_count, 1);
    chk("abort_busy", busy, 0);
    vs_pulse();
    strobes(15, 0);
    chk("fresh_busy15", busy, 1);
    chk("fresh_done15", n_done - bd, 0);
    strobes(1, 0);
    repeat (2) @(negedge mclk);
    chk("fresh_done16", n_done - bd, 1);
    chk("fresh_sent", sent_count, 1);

    // 16th strobe lands on the same edge that sees vs_fall
    do_reset();
    setup(1'b1, 4'd0);
    vs_pulse();
    strobes(15, 0);
    bd = n_done; ba = n_abort;
    @(negedge mclk) v_sync = 1'b0;
    @(negedge mclk);
    @(negedge mclk) begin pix_strobe = 1'b1; datavalid = 1'b1; end
    @(posedge mclk); #1;
    chk("sim_done_now", frame_done, 1);
    chk("sim_send_drop", send_frame, 0);
    @(negedge mclk) begin pix_strobe = 1'b0; datavalid = 1'b0; v_sync = 1'b1; end
    repeat (4) @(negedge mclk);
    chk("sim_dones", n_done - bd, 1);
    chk("sim_aborts", n_abort - ba, 0);
    chk("sim_sent", sent_count, 1);
    chk("sim_drop", dropped_count, 0);

    // asynchronous reset in the middle of a frame
    vs_pulse();
    strobes(5, 0);
    chk("pre_rst_busy", busy, 1);
    @(negedge mclk); #2 reset = 1'b1;
    #1;
    chk("arst_flags", {send_frame, busy, frame_start, frame_done, frame_abort}, 0);
    chk("arst_sent", sent_count, 0);

    // enable and cts drop mid-frame: frame still completes, then IDLE ignores edges
    do_reset();
    setup(1'b1, 4'd0);
    vs_pulse();
    strobes(5, 0);
    @(negedge mclk) begin enable = 1'b0; cts = 1'b0; end
    strobes(11, 0);
    repeat (3) @(negedge mclk);
    chk("en_sent", sent_count, 1);
    chk("en_busy", busy, 0);
    bs = n_start;
    vs_pulse();
    chk("idle_starts", n_start - bs, 0);
    chk("idle_drop", dropped_count, 0);
    chk("idle_send", send_frame, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
